word_serializer: RTL and testbench

Upstream stage that feeds the 1-bit `IN` data input of the TOP register pipeline. It accepts parallel words over a valid/ready handshake and emits each word as a framed serial bit stream, one bit per `CLK`, on `SOUT`. `SOUT_EN` marks frame bits and can drive TOP's `IN2` qualifier.

---
 rtl/word_serializer_pkg.sv | 20 ++
 rtl/word_serializer.sv | 155 +++++++++++++++
 tb/tb_word_serializer.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/word_serializer_pkg.sv
// Shared types and constants for the parallel-to-serial framer.
package word_serializer_pkg;

   localparam logic [2:0] ENC_IDLE   = 3'd0;
   localparam logic [2:0] ENC_START  = 3'd1;
   localparam logic [2:0] ENC_SHIFT  = 3'd2;
   localparam logic [2:0] ENC_PARITY = 3'd3;
   localparam logic [2:0] ENC_GAP    = 3'd4;

   typedef enum logic [2:0] {
      S_IDLE   = ENC_IDLE,
      S_START  = ENC_START,
      S_SHIFT  = ENC_SHIFT,
      S_PARITY = ENC_PARITY,
      S_GAP    = ENC_GAP
   } state_e;

   localparam logic SOUT_IDLE = 1'b0;

endpackage

// File: rtl/word_serializer.sv
// Accepts a parallel word over valid/ready and emits it MSB first as a
// framed serial stream: start bit, data bits, optional even parity, idle gap.
module word_serializer
   import word_serializer_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int PARITY_EN  = 1,
   parameter int GAP_CYCLES = 1
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [WIDTH-1:0] DIN,
   input  logic             DIN_VALID,
   output logic             DIN_READY,
   output logic             SOUT,
   output logic             SOUT_EN,
   output logic             BUSY,
   output logic             DONE
);

   localparam int CW = $clog2(WIDTH);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic             par_q, par_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             sout_q, sout_d;
   logic             en_q, en_d;
   logic             ready_q, ready_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             gap_last;

   generate
      if (GAP_CYCLES > 0) begin : g_gap
         localparam int GW = $clog2(GAP_CYCLES + 1);
         logic [GW-1:0] gap_cnt_q, gap_cnt_d;

         // Reloads whenever outside GAP so it is primed on entry.
         always_comb begin
            gap_cnt_d = GW'(GAP_CYCLES - 1);
            if (state_q == S_GAP) gap_cnt_d = gap_cnt_q - GW'(1);
         end

         always_ff @(posedge CLK) gap_cnt_q <= gap_cnt_d;

         assign gap_last = (gap_cnt_q == '0);
      end else begin : g_no_gap
         assign gap_last = 1'b1;
      end
   endgenerate

   // Every output is computed for the state being entered, then registered.
   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      par_d   = par_q;
      cnt_d   = cnt_q;
      sout_d  = SOUT_IDLE;
      en_d    = 1'b0;
      ready_d = 1'b0;
      busy_d  = 1'b1;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            ready_d = 1'b1;
            busy_d  = 1'b0;
            if (DIN_VALID && ready_q) begin
               state_d = S_START;
               shreg_d = DIN;
               par_d   = ^DIN;
               sout_d  = 1'b1;
               en_d    = 1'b1;
               ready_d = 1'b0;
               busy_d  = 1'b1;
            end
         end
         S_START: begin
            state_d = S_SHIFT;
            cnt_d   = CW'(WIDTH - 1);
            sout_d  = shreg_q[WIDTH-1];
            shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
            en_d    = 1'b1;
         end
         S_SHIFT: begin
            if (cnt_q != '0) begin
               cnt_d   = cnt_q - CW'(1);
               sout_d  = shreg_q[WIDTH-1];
               shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
               en_d    = 1'b1;
               done_d  = (PARITY_EN == 0) && (cnt_q == CW'(1));
            end else if (PARITY_EN != 0) begin
               state_d = S_PARITY;
               sout_d  = par_q;
               en_d    = 1'b1;
               done_d  = 1'b1;
            end else if (GAP_CYCLES > 0) begin
               state_d = S_GAP;
            end else begin
               state_d = S_IDLE;
               ready_d = 1'b1;
               busy_d  = 1'b0;
            end
         end
         S_PARITY: begin
            if (GAP_CYCLES > 0) begin
               state_d = S_GAP;
            end else begin
               state_d = S_IDLE;
               ready_d = 1'b1;
               busy_d  = 1'b0;
            end
         end
         S_GAP: begin
            if (gap_last) begin
               state_d = S_IDLE;
               ready_d = 1'b1;
               busy_d  = 1'b0;
            end
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      shreg_q <= shreg_d;
      par_q   <= par_d;
      cnt_q   <= cnt_d;
      if (RST) begin
         state_q <= S_IDLE;
         sout_q  <= SOUT_IDLE;
         en_q    <= 1'b0;
         ready_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sout_q  <= sout_d;
         en_q    <= en_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign DIN_READY = ready_q;
   assign SOUT      = sout_q;
   assign SOUT_EN   = en_q;
   assign BUSY      = busy_q;
   assign DONE      = done_q;

endmodule

// File: tb/tb_word_serializer.sv
// Directed bench for word_serializer across three parameter sets.
module tb_word_serializer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic [7:0] din_a, din_b;
   logic [1:0] din_c;
   logic       vld_a, vld_b, vld_c;
   logic       ready_a, sout_a, en_a, busy_a, done_a;
   logic       ready_b, sout_b, en_b, busy_b, done_b;
   logic       ready_c, sout_c, en_c, busy_c, done_c;

   int checks   = 0;
   int failures = 0;
   int sel      = 0;

   logic m_sout, m_en, m_busy, m_ready, m_done;

   word_serializer #(.WIDTH(8), .PARITY_EN(1), .GAP_CYCLES(1)) u_a (
      .CLK(clk), .RST(rst), .DIN(din_a), .DIN_VALID(vld_a), .DIN_READY(ready_a),
      .SOUT(sout_a), .SOUT_EN(en_a), .BUSY(busy_a), .DONE(done_a));

   word_serializer #(.WIDTH(8), .PARITY_EN(0), .GAP_CYCLES(0)) u_b (
      .CLK(clk), .RST(rst), .DIN(din_b), .DIN_VALID(vld_b), .DIN_READY(ready_b),
      .SOUT(sout_b), .SOUT_EN(en_b), .BUSY(busy_b), .DONE(done_b));

   word_serializer #(.WIDTH(2), .PARITY_EN(1), .GAP_CYCLES(1)) u_c (
      .CLK(clk), .RST(rst), .DIN(din_c), .DIN_VALID(vld_c), .DIN_READY(ready_c),
      .SOUT(sout_c), .SOUT_EN(en_c), .BUSY(busy_c), .DONE(done_c));

   always_comb begin
      m_sout = sout_a; m_en = en_a; m_busy = busy_a; m_ready = ready_a; m_done = done_a;
      case (sel)
         1: begin m_sout = sout_b; m_en = en_b; m_busy = busy_b; m_ready = ready_b; m_done = done_b; end
         2: begin m_sout = sout_c; m_en = en_c; m_busy = busy_c; m_ready = ready_c; m_done = done_c; end
         default: ;
      endcase
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic s, input logic e,
                          input logic b, input logic r, input logic d);
      chk({tag, "_sout"},  m_sout,  s);
      chk({tag, "_en"},    m_en,    e);
      chk({tag, "_busy"},  m_busy,  b);
      chk({tag, "_ready"}, m_ready, r);
      chk({tag, "_done"},  m_done,  d);
   endtask

   // Starts on the start bit; ends one edge after the last frame bit.
   task automatic frame(input string tag, input int n, input logic [15:0] seq);
      for (int i = 0; i < n; i++) begin
         chk_all($sformatf("%s_b%0d", tag, i), seq[n-1-i], 1'b1, 1'b1, 1'b0, (i == n-1));
         tick();
      end
   endtask

   initial begin
      rst = 1'b1;
      din_a = 8'h00; din_b = 8'h00; din_c = 2'b00;
      vld_a = 1'b0; vld_b = 1'b0; vld_c = 1'b0;
      tick(); tick();
      for (int s = 0; s < 3; s++) begin
         sel = s; #0;
         chk_all($sformatf("rst%0d", s), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      rst = 1'b0;
      tick();
      for (int s = 0; s < 3; s++) begin
         sel = s; #0;
         chk_all($sformatf("rel%0d", s), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      end

      sel = 0;
      for (int i = 0; i < 20; i++) begin
         chk_all($sformatf("idle%0d", i), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
         tick();
      end

      din_a = 8'hA5; vld_a = 1'b1;
      tick();
      vld_a = 1'b0; din_a = 8'h00;
      frame("a5", 10, 16'b1101001010);
      chk_all("a5_gap", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      chk_all("a5_end", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

      din_a = 8'h01; vld_a = 1'b1;
      tick();
      din_a = 8'hFF;
      frame("b2b1", 10, 16'b1000000011);
      chk_all("b2b1_gap", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      chk_all("b2b_rdy", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      vld_a = 1'b0;
      frame("b2b2", 10, 16'b1111111110);
      chk_all("b2b2_gap", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      chk_all("b2b2_end", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

      din_a = 8'hC3; vld_a = 1'b1;
      tick();
      vld_a = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk_all($sformatf("c3_b%0d", i), (i < 3), 1'b1, 1'b1, 1'b0, 1'b0);
         if (i < 4) tick();
      end
      rst = 1'b1;
      tick();
      chk_all("abort", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      tick();
      chk_all("abort_rel", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      din_a = 8'h3C; vld_a = 1'b1;
      tick();
      vld_a = 1'b0;
      frame("3c", 10, 16'b1001111000);
      chk_all("3c_gap", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      chk_all("3c_end", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

      sel = 1; #0;
      chk_all("p0g0_pre", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      din_b = 8'h80; vld_b = 1'b1;
      tick();
      vld_b = 1'b0;
      frame("p0g0", 9, 16'b110000000);
      chk_all("p0g0_end", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

      sel = 2; #0;
      chk_all("w2_pre", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      din_c = 2'b10; vld_c = 1'b1;
      tick();
      vld_c = 1'b0;
      frame("w2", 4, 16'b1101);
      chk_all("w2_gap", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      chk_all("w2_end", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
